// File: rtl/multicycle_control.sv
// multicycle_control: multicycle FSM sequencing fetch/decode/execute for an 8-instruction subset
module multicycle_control (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] opcode,
    input  logic        alu_zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_sel,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        halt,
    output logic [3:0]  state,
    output logic [31:0] retired
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC_R = 4'd2,
        S_ADDR   = 4'd3,
        S_MEM_RD = 4'd4,
        S_MEM_WR = 4'd5,
        S_WB_R   = 4'd6,
        S_WB_LD  = 4'd7,
        S_CBZ    = 4'd8,
        S_BR     = 4'd9,
        S_HALT   = 4'd10
    } state_t;
    state_t      r_state, w_next;
    logic [31:0] r_retired;
    logic        w_is_r, w_is_ld, w_is_st, w_is_cbz, w_is_b, w_retire;
    assign w_is_r   = opcode == 11'b10001011000 || opcode == 11'b11001011000 ||
                      opcode == 11'b10001010000 || opcode == 11'b10101010000;
    assign w_is_ld  = opcode == 11'b11111000010;
    assign w_is_st  = opcode == 11'b11111000000;
    assign w_is_cbz = opcode[10:3] == 8'b10110100;
    assign w_is_b   = opcode[10:5] == 6'b000101;
    assign w_retire = r_state == S_WB_R || r_state == S_WB_LD || r_state == S_CBZ ||
                      r_state == S_BR || (r_state == S_MEM_WR && mem_ready);
    assign state    = r_state;
    assign retired  = r_retired;
    // next-state selection; only FETCH, MEM_RD and MEM_WR look at mem_ready
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_is_r ? S_EXEC_R : (w_is_ld || w_is_st) ? S_ADDR :
                               w_is_cbz ? S_CBZ : w_is_b ? S_BR : S_HALT;
            S_EXEC_R: w_next = S_WB_R;
            S_ADDR:   w_next = w_is_st ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: w_next = mem_ready ? S_WB_LD : S_MEM_RD;
            S_MEM_WR: w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end
    // per-state control decode, forced to zero while reset is held
    always_comb begin
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_sel    = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        halt       = 1'b0;
        if (reset_n) begin
            case (r_state)
                S_FETCH: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: reg2loc = w_is_st || w_is_cbz;
                S_EXEC_R: alu_op = 2'b10;
                S_WB_R: begin
                    reg_write = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ADDR: alu_src = 1'b1;
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    mem_sel  = 1'b1;
                    alu_src  = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    mem_sel   = 1'b1;
                    alu_src   = 1'b1;
                    reg2loc   = 1'b1;
                end
                S_WB_LD: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_CBZ: begin
                    reg2loc  = 1'b1;
                    alu_op   = 2'b01;
                    pc_src   = 1'b1;
                    pc_write = alu_zero;
                end
                S_BR: begin
                    pc_src   = 1'b1;
                    pc_write = 1'b1;
                end
                S_HALT: halt = 1'b1;
                default: ;
            endcase
        end
    end
    // state register and retired-instruction counter; reset aborts any pending wait
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= S_FETCH;
            r_retired <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_retired <= r_retired + 32'd1;
        end
    end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: randomized instruction stream checked against a per-instruction trace model
module tb_multicycle_control;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] opcode = 11'd0;
    logic        alu_zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic        pc_write, pc_src, ir_write, mem_read, mem_write, mem_sel;
    logic        reg2loc, alu_src, reg_write, mem_to_reg, halt;
    logic [1:0]  alu_op;
    logic [3:0]  state;
    logic [31:0] retired;
    logic [13:0] w_ctl;
    int          passed = 0;
    int          total = 0;
    logic [31:0] exp_retired = 32'd0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;

    multicycle_control dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .alu_zero(alu_zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
        .mem_sel(mem_sel), .reg2loc(reg2loc), .alu_src(alu_src), .alu_op(alu_op),
        .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halt(halt),
        .state(state), .retired(retired)
    );

    assign w_ctl = {pc_write, pc_src, ir_write, mem_read, mem_write, mem_sel,
                    reg2loc, alu_src, alu_op, reg_write, mem_to_reg, halt};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // instruction class: 0 R-type, 1 load, 2 store, 3 cbz, 4 branch, 5 illegal
    function automatic int kind_of(input logic [10:0] op);
        if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return 0;
        if (op == OP_LDUR) return 1;
        if (op == OP_STUR) return 2;
        if (op ==? 11'b10110100???) return 3;
        if (op ==? 11'b000101?????) return 4;
        return 5;
    endfunction

    // expected control bundle for a given phase of an instruction
    function automatic logic [13:0] exp_ctl(input int st, input logic [10:0] op,
                                            input logic mr, input logic z);
        logic pw, ps, irw, mrd, mwr, msel, r2l, asrc, rw, m2r, hlt;
        logic [1:0] aop;
        {pw, ps, irw, mrd, mwr, msel, r2l, asrc, rw, m2r, hlt} = '0;
        aop = 2'b00;
        case (st)
            0:  begin mrd = 1; irw = mr; pw = mr; end
            1:  r2l = (kind_of(op) == 2 || kind_of(op) == 3);
            2:  aop = 2'b10;
            3:  asrc = 1;
            4:  begin mrd = 1; msel = 1; asrc = 1; end
            5:  begin mwr = 1; msel = 1; asrc = 1; r2l = 1; end
            6:  begin rw = 1; aop = 2'b10; end
            7:  begin rw = 1; m2r = 1; end
            8:  begin r2l = 1; aop = 2'b01; ps = 1; pw = z; end
            9:  begin ps = 1; pw = 1; end
            10: hlt = 1;
            default: ;
        endcase
        return {pw, ps, irw, mrd, mwr, msel, r2l, asrc, aop, rw, m2r, hlt};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drive one whole instruction and check every cycle against the expected trace
    task automatic run_instr(input logic [10:0] op, input int fw, input int mw, input logic z);
        int st_q[$];
        logic mr_q[$];
        int k = kind_of(op);
        for (int i = 0; i < fw; i++) begin st_q.push_back(0); mr_q.push_back(1'b0); end
        st_q.push_back(0); mr_q.push_back(1'b1);
        st_q.push_back(1); mr_q.push_back(1'($urandom));
        case (k)
            0: begin
                st_q.push_back(2); mr_q.push_back(1'($urandom));
                st_q.push_back(6); mr_q.push_back(1'($urandom));
            end
            1, 2: begin
                st_q.push_back(3); mr_q.push_back(1'($urandom));
                for (int i = 0; i < mw; i++) begin st_q.push_back(k == 1 ? 4 : 5); mr_q.push_back(1'b0); end
                st_q.push_back(k == 1 ? 4 : 5); mr_q.push_back(1'b1);
                if (k == 1) begin st_q.push_back(7); mr_q.push_back(1'($urandom)); end
            end
            3: begin st_q.push_back(8); mr_q.push_back(1'($urandom)); end
            4: begin st_q.push_back(9); mr_q.push_back(1'($urandom)); end
            default: begin st_q.push_back(10); mr_q.push_back(1'($urandom)); end
        endcase
        for (int i = 0; i < st_q.size(); i++) begin
            logic zz;
            zz = (st_q[i] == 8) ? z : 1'($urandom);
            opcode = op;
            mem_ready = mr_q[i];
            alu_zero = zz;
            #1;
            total++;
            if (state !== 4'(st_q[i]))
                $display("FAIL state op=%b step %0d: got %0d expected %0d", op, i, state, st_q[i]);
            else passed++;
            total++;
            if (w_ctl !== exp_ctl(st_q[i], op, mr_q[i], zz))
                $display("FAIL ctl op=%b step %0d: got %b expected %b", op, i, w_ctl, exp_ctl(st_q[i], op, mr_q[i], zz));
            else passed++;
            if (k == 5 && i == st_q.size() - 1) return;
            tick();
        end
        exp_retired++;
        mem_ready = 1'b0;
        total++;
        if (retired !== exp_retired)
            $display("FAIL retired op=%b: got %0d expected %0d", op, retired, exp_retired);
        else passed++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        total++;
        if (w_ctl !== 14'd0) $display("FAIL reset_ctl: got %b expected 0", w_ctl); else passed++;
        total++;
        if (retired !== 32'd0) $display("FAIL reset_retired: got %0d expected 0", retired); else passed++;
        total++;
        if (state !== 4'd0) $display("FAIL reset_state: got %0d expected 0", state); else passed++;
        mem_ready = 1'b0;
        reset_n = 1'b1;
        #1;
        total++;
        if (mem_read !== 1'b1 || state !== 4'd0)
            $display("FAIL reset_release: got state %0d mem_read %b expected 0/1", state, mem_read);
        else passed++;
        exp_retired = 32'd0;
        tick();
    endtask

    task automatic test_add();
        run_instr(OP_ADD, 0, 0, 1'b0);
    endtask

    task automatic test_ldur_wait();
        run_instr(OP_LDUR, 1, 3, 1'b0);
        run_instr(OP_STUR, 2, 2, 1'b0);
    endtask

    task automatic test_cbz();
        run_instr(11'b10110100101, 0, 0, 1'b1);
        run_instr(11'b10110100010, 0, 0, 1'b0);
    endtask

    task automatic test_wrap();
        force dut.r_retired = 32'hFFFF_FFFF;
        tick();
        release dut.r_retired;
        #1;
        total++;
        if (retired !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h expected ffffffff", retired); else passed++;
        exp_retired = 32'hFFFF_FFFF;
        run_instr(11'b00010110011, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [10:0] op;
            case ($urandom_range(0, 7))
                0: op = OP_ADD;
                1: op = OP_SUB;
                2: op = OP_AND;
                3: op = OP_ORR;
                4: op = OP_LDUR;
                5: op = OP_STUR;
                6: op = {8'b10110100, 3'($urandom)};
                default: op = {6'b000101, 5'($urandom)};
            endcase
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
        end
    endtask

    task automatic test_reset_memwr();
        opcode = OP_STUR;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        tick();
        total++;
        if (state !== 4'd5 || mem_write !== 1'b1)
            $display("FAIL memwr_entry: got state %0d mem_write %b expected 5/1", state, mem_write);
        else passed++;
        reset_n = 1'b0;
        #1;
        total++;
        if (mem_write !== 1'b0) $display("FAIL memwr_gate: got %b expected 0", mem_write); else passed++;
        tick();
        total++;
        if (state !== 4'd0 || retired !== 32'd0 || w_ctl !== 14'd0)
            $display("FAIL memwr_abort: got state %0d retired %0d ctl %b expected 0/0/0", state, retired, w_ctl);
        else passed++;
        reset_n = 1'b1;
        exp_retired = 32'd0;
        tick();
    endtask

    task automatic test_halt();
        run_instr(11'b11111111111, 0, 0, 1'b0);
        tick();
        for (int i = 0; i < 100; i++) begin
            mem_ready = 1'($urandom);
            alu_zero = 1'($urandom);
            #1;
            total++;
            if (state !== 4'd10 || w_ctl !== exp_ctl(10, opcode, mem_ready, alu_zero))
                $display("FAIL halt_hold %0d: got state %0d ctl %b expected 10/%b", i, state, w_ctl, exp_ctl(10, opcode, mem_ready, alu_zero));
            else passed++;
            tick();
        end
        reset_n = 1'b0;
        tick();
        total++;
        if (halt !== 1'b0 || state !== 4'd0 || retired !== 32'd0)
            $display("FAIL halt_clear: got halt %b state %0d retired %0d expected 0/0/0", halt, state, retired);
        else passed++;
        reset_n = 1'b1;
        mem_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldur_wait();
        test_cbz();
        test_wrap();
        test_random();
        test_reset_memwr();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
